// File: rtl/regbank_write_arbiter.sv
// Round-robin write-bus arbiter for a register bank; the grant is registered and visible in the cycle after the edge that issues it.
// stall blocks new grants but never cancels one already on the outputs; the last-acked requester is masked from the next grant.
module regbank_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 10,
  parameter int NREG  = 4,
  parameter int AW    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*AW-1:0]    req_addr,
  output logic [NREQ-1:0]       ack,
  output logic [NREG-1:0]       reg_en,
  output logic [WIDTH-1:0]      bus_data,
  output logic                  busy,
  output logic                  err_addr
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic [PW-1:0]    win_next;
  logic             found;
  logic [NREQ-1:0]  eligible;
  logic [WIDTH-1:0] win_data;
  logic [AW-1:0]    win_addr;
  logic             addr_ok;

  // A requester acked this cycle cannot win again at the coming edge.
  assign eligible = req & ~ack;

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign win_data = req_data[win*WIDTH +: WIDTH];
  assign win_addr = req_addr[win*AW +: AW];
  assign addr_ok  = {1'b0, win_addr} < (AW+1)'(NREG);
  assign win_next = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      ack      <= '0;
      reg_en   <= '0;
      bus_data <= '0;
      busy     <= 1'b0;
      err_addr <= 1'b0;
      ptr      <= '0;
    end else if (stall || !found) begin
      // bus_data deliberately holds its last value when idle.
      ack    <= '0;
      reg_en <= '0;
      busy   <= 1'b0;
    end else begin
      ack      <= NREQ'(1) << win;
      bus_data <= win_data;
      reg_en   <= addr_ok ? (NREG'(1) << win_addr) : '0;
      if (!addr_ok) err_addr <= 1'b1;
      busy     <= 1'b1;
      ptr      <= win_next;
    end
  end
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_regbank_write_arbiter;
  localparam int NREQ = 4, WIDTH = 10, NREG = 4, AW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ*AW-1:0]    req_addr = '0;
  logic [NREQ-1:0] ack, ack3;
  logic [NREG-1:0] reg_en;
  logic [2:0]      reg_en3;
  logic [WIDTH-1:0] bus_data, bus_data3;
  logic busy, busy3, err_addr, err_addr3;

  always #5 clk = ~clk;

  regbank_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .req_data(req_data), .req_addr(req_addr),
    .ack(ack), .reg_en(reg_en), .bus_data(bus_data), .busy(busy), .err_addr(err_addr));

  regbank_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .NREG(3), .AW(AW)) dut3 (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .req_data(req_data), .req_addr(req_addr),
    .ack(ack3), .reg_en(reg_en3), .bus_data(bus_data3), .busy(busy3), .err_addr(err_addr3));

  // Register bank fed by the arbiter outputs.
  logic [WIDTH-1:0] bank [NREG];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) if (reg_en[i]) bank[i] <= bus_data;
    end
  end

  // Reference model state.
  logic [NREQ-1:0]  e_ack = '0;
  logic [NREG-1:0]  e_en = '0;
  logic [2:0]       e3_en = '0;
  logic [WIDTH-1:0] e_bus = '0;
  logic             e_busy = 1'b0;
  logic             e3_err = 1'b0;
  int               e_ptr = 0;
  logic [WIDTH-1:0] e_bank [NREG];

  int checks = 0;
  int errors = 0;

  function automatic int pick(logic [NREQ-1:0] r, logic [NREQ-1:0] last, int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (r[i] && !last[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [19:0] obs();
    return {ack, reg_en, bus_data, busy, err_addr};
  endfunction
  function automatic logic [19:0] exp_v();
    return {e_ack, e_en, e_bus, e_busy, 1'b0};
  endfunction
  function automatic logic [18:0] obs3();
    return {ack3, reg_en3, bus_data3, busy3, err_addr3};
  endfunction
  function automatic logic [18:0] exp3();
    return {e_ack, e3_en, e_bus, e_busy, e3_err};
  endfunction

  // Advance one clock: model computes from the pre-edge inputs, outputs sampled 1ns after.
  task automatic step();
    int w, a;
    w = pick(req, e_ack, e_ptr);
    @(posedge clk);
    if (reset) begin
      e_ack = '0; e_en = '0; e3_en = '0; e_bus = '0; e_busy = 1'b0; e3_err = 1'b0; e_ptr = 0;
      for (int i = 0; i < NREG; i++) e_bank[i] = '0;
    end else begin
      for (int i = 0; i < NREG; i++) if (e_en[i]) e_bank[i] = e_bus;
      if (stall || w < 0) begin
        e_ack = '0; e_en = '0; e3_en = '0; e_busy = 1'b0;
      end else begin
        e_ack  = NREQ'(1 << w);
        e_bus  = req_data[w*WIDTH +: WIDTH];
        a      = int'(req_addr[w*AW +: AW]);
        e_en   = (a < NREG) ? NREG'(1 << a) : '0;
        e3_en  = (a < 3) ? 3'(1 << a) : 3'b000;
        if (a >= 3) e3_err = 1'b1;
        e_busy = 1'b1;
        e_ptr  = (w + 1) % NREQ;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; req = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111;
    req_data = {$urandom, $urandom};
    req_addr = 8'($urandom);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({obs(), err_addr3} !== 21'h0) begin
        errors++; $display("FAIL reset_outputs: got %h required 0", {obs(), err_addr3});
      end
    end
    reset = 1'b0;
    step();
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL reset_first_ack: got %b required 0001", ack); end
    checks++;
    if (reg_en !== (4'b0001 << req_addr[1:0])) begin
      errors++; $display("FAIL reset_first_en: got %b addr %0d", reg_en, req_addr[1:0]);
    end
    checks++;
    if (obs() !== exp_v()) begin errors++; $display("FAIL reset_model: got %h required %h", obs(), exp_v()); end
    req = '0;
    step(); step();
  endtask

  task automatic test_single();
    int nack = 0;
    bit got = 0;
    do_reset();
    req = 4'b0100;
    req_data[2*WIDTH +: WIDTH] = 10'h2A5;
    req_addr[2*AW +: AW] = 2'd3;
    for (int c = 0; c < 6 && !got; c++) begin
      step();
      if (ack[2]) begin got = 1; nack++; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL single_timeout: no ack within 6 cycles"); end
    checks++;
    if ({ack, reg_en, bus_data} !== {4'b0100, 4'b1000, 10'h2A5}) begin
      errors++; $display("FAIL single_grant: got ack %b en %b data %h required 0100 1000 2a5", ack, reg_en, bus_data);
    end
    checks++;
    if (obs() !== exp_v()) begin errors++; $display("FAIL single_model: got %h required %h", obs(), exp_v()); end
    req = '0;
    step();
    checks++;
    if (bank[3] !== 10'h2A5) begin errors++; $display("FAIL single_bank: got %h required 2a5", bank[3]); end
    if (ack[2]) nack++;
    for (int c = 0; c < 3; c++) begin step(); if (ack[2]) nack++; end
    checks++;
    if (nack !== 1) begin errors++; $display("FAIL single_ack_count: got %0d required 1", nack); end
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] d [NREQ];
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      d[i] = WIDTH'(i * 97 + 10'h055 + (i << 8));
      req_data[i*WIDTH +: WIDTH] = d[i];
      req_addr[i*AW +: AW] = AW'(i);
    end
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (ack !== 4'(1 << (c % NREQ)) || bus_data !== d[c % NREQ]) begin
        errors++; $display("FAIL rr_order[%0d]: got ack %b data %h required %b %h", c, ack, bus_data, 4'(1 << (c % NREQ)), d[c % NREQ]);
      end
      checks++;
      if (obs() !== exp_v()) begin errors++; $display("FAIL rr_model[%0d]: got %h required %h", c, obs(), exp_v()); end
    end
    req = '0;
    step();
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] d0;
    logic [AW-1:0] a0;
    do_reset();
    req_data = {$urandom, $urandom};
    req_addr = 8'($urandom);
    d0 = req_data[0 +: WIDTH];
    a0 = req_addr[0 +: AW];
    req = 4'b0011;
    step();
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL stall_pre: got %b required 0001", ack); end
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (ack !== 4'b0000 || busy !== 1'b0 || obs() !== exp_v()) begin
        errors++; $display("FAIL stall_hold[%0d]: got ack %b busy %b required 0000 0", c, ack, busy);
      end
      if (c == 0) begin
        checks++;
        if (bank[a0] !== d0) begin errors++; $display("FAIL stall_inflight: got %h required %h", bank[a0], d0); end
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (ack !== 4'b0010 || obs() !== exp_v()) begin
      errors++; $display("FAIL stall_resume: got %b required 0010", ack);
    end
    req = '0;
    step();
  endtask

  task automatic test_bad_addr();
    do_reset();
    req = 4'b0010;
    req_addr[1*AW +: AW] = 2'b11;
    step();
    checks++;
    if ({ack3, reg_en3, err_addr3} !== {4'b0010, 3'b000, 1'b1}) begin
      errors++; $display("FAIL bad_addr3: got ack %b en %b err %b required 0010 000 1", ack3, reg_en3, err_addr3);
    end
    checks++;
    if (reg_en !== 4'b1000 || err_addr !== 1'b0) begin
      errors++; $display("FAIL bad_addr4: got en %b err %b required 1000 0", reg_en, err_addr);
    end
    req = '0;
    for (int c = 0; c < 4; c++) begin
      req = 4'($urandom);
      req_addr = 8'($urandom) & 8'h55;
      step();
      checks++;
      if (err_addr3 !== 1'b1) begin errors++; $display("FAIL bad_addr_sticky[%0d]: got %b required 1", c, err_addr3); end
    end
    req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    step();
    checks++;
    if (ack !== 4'b0100) begin errors++; $display("FAIL rmid_pre: got %b required 0100", ack); end
    reset = 1'b1; req = 4'b1111;
    step();
    checks++;
    if ({ack, reg_en, busy} !== 9'h0) begin errors++; $display("FAIL rmid_clear: got ack %b en %b", ack, reg_en); end
    reset = 1'b0;
    step();
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL rmid_restart: got %b required 0001", ack); end
    step();
    checks++;
    if (ack !== 4'b0010 || obs() !== exp_v()) begin errors++; $display("FAIL rmid_next: got %b required 0010", ack); end
    req = '0;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 4) == 0);
      req = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        req_data = {$urandom, $urandom};
        req_addr = 8'($urandom);
      end
      step();
      checks++;
      if (obs() !== exp_v()) begin errors++; $display("FAIL rand_out[%0d]: got %h required %h", c, obs(), exp_v()); end
      checks++;
      if (obs3() !== exp3()) begin errors++; $display("FAIL rand_out3[%0d]: got %h required %h", c, obs3(), exp3()); end
      for (int i = 0; i < NREG; i++) begin
        checks++;
        if (bank[i] !== e_bank[i]) begin errors++; $display("FAIL rand_bank%0d[%0d]: got %h required %h", i, c, bank[i], e_bank[i]); end
      end
    end
    reset = 1'b0; stall = 1'b0; req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_bad_addr();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
